// File: rtl/bvh_node_fetch_arbiter.sv
// Purpose : shares one BVH node RAM read port between NUM_REQ traversal units (round-robin).
// Latency : combinational grant; response MEM_LATENCY cycles after the grant (null fetches too).
// Backpressure: req held until gnt; one fetch in flight per unit; responses never stall.
//
// Ports:
//   clk, reset (async, active-high), flush (sync, abandons all outstanding fetches)
//   req/req_index     : per-unit fetch request and node index (MSB=1 marks leaf/none)
//   gnt               : one-hot combinational grant
//   mem_en/mem_addr   : node RAM read enable and address
//   mem_rdata         : node RAM read data, MEM_LATENCY cycles after mem_en
//   rsp_valid/rsp_null/rsp_data : one-hot response strobe, null marker, node record
//   busy              : any fetch pending
module bvh_node_fetch_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int IDX_W       = 8,
  parameter int DATA_W      = 224,
  parameter int MEM_LATENCY = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0][IDX_W-1:0] req_index,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          mem_en,
  output logic [IDX_W-2:0]              mem_addr,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic                          rsp_null,
  output logic [DATA_W-1:0]             rsp_data,
  output logic                          busy
);

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int LAST = MEM_LATENCY - 1;

  logic [ID_W-1:0]    ptr;
  logic [NUM_REQ-1:0] pending;
  logic [NUM_REQ-1:0] eligible;
  logic [ID_W-1:0]    win;
  logic               any_gnt;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_null;
  int                 scan_idx;

  // Tag pipeline: stage 0 is loaded on grant, the last stage drives the response.
  logic [MEM_LATENCY-1:0] st_vld;
  logic [MEM_LATENCY-1:0] st_null;
  logic [ID_W-1:0]        st_id [MEM_LATENCY];

  logic rsp_any;

  // Reset is folded in so the grant drops the instant reset asserts, not at the next edge.
  assign eligible = req & ~pending & ~{NUM_REQ{flush | reset}};

  // Round-robin scan starting at ptr, wrapping modulo NUM_REQ.
  always_comb begin
    win      = '0;
    any_gnt  = 1'b0;
    scan_idx = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = (int'(ptr) + k) % NUM_REQ;
      if (!any_gnt && eligible[scan_idx]) begin
        any_gnt = 1'b1;
        win     = ID_W'(scan_idx);
      end
    end
  end

  assign sel_idx  = req_index[win];
  assign sel_null = sel_idx[IDX_W-1];

  always_comb begin
    gnt = '0;
    if (any_gnt) gnt[win] = 1'b1;
  end

  // Null indices are granted and tracked but never touch the RAM.
  assign mem_en   = any_gnt & ~sel_null;
  assign mem_addr = mem_en ? sel_idx[IDX_W-2:0] : '0;

  // Flush suppresses the response in its own cycle; the RAM data is simply ignored.
  assign rsp_any = st_vld[LAST] & ~flush;

  always_comb begin
    rsp_valid = '0;
    if (rsp_any) rsp_valid[st_id[LAST]] = 1'b1;
  end

  assign rsp_null = rsp_any & st_null[LAST];
  assign rsp_data = (rsp_any && !st_null[LAST]) ? mem_rdata : '0;
  assign busy     = |pending;

  // ptr survives flush so fairness carries across ray restarts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (any_gnt) begin
      ptr <= (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
    end
  end

  // A unit can't be granted and answered in the same cycle, so set/clear never collide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
    end else if (flush) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~rsp_valid) | gnt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_vld  <= '0;
      st_null <= '0;
      for (int s = 0; s < MEM_LATENCY; s++) st_id[s] <= '0;
    end else begin
      st_vld[0]  <= any_gnt;
      st_null[0] <= sel_null;
      st_id[0]   <= win;
      for (int s = 1; s < MEM_LATENCY; s++) begin
        st_vld[s]  <= st_vld[s-1];
        st_null[s] <= st_null[s-1];
        st_id[s]   <= st_id[s-1];
      end
      if (flush) st_vld <= '0;
    end
  end

endmodule

// File: tb/tb_bvh_node_fetch_arbiter.sv
module tb_bvh_node_fetch_arbiter;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 8;
  localparam int DATA_W  = 224;

  logic                          clk = 1'b0;
  logic                          reset;
  logic                          flush;
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0][IDX_W-1:0] req_index;
  logic [NUM_REQ-1:0]            gnt;
  logic                          mem_en;
  logic [IDX_W-2:0]              mem_addr;
  logic [DATA_W-1:0]             mem_rdata;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic                          rsp_null;
  logic [DATA_W-1:0]             rsp_data;
  logic                          busy;

  int checks   = 0;
  int failures = 0;
  int gcnt [NUM_REQ];

  always #5 clk = ~clk;

  bvh_node_fetch_arbiter #(
    .NUM_REQ(NUM_REQ), .IDX_W(IDX_W), .DATA_W(DATA_W), .MEM_LATENCY(2)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush), .req(req), .req_index(req_index),
    .gnt(gnt), .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_null(rsp_null), .rsp_data(rsp_data), .busy(busy)
  );

  // Node RAM model: two-cycle read latency, junk on the bus when nothing was read.
  function automatic logic [DATA_W-1:0] ram_word(input logic [IDX_W-2:0] a);
    return {7{32'hC0DE0000 | {25'd0, a}}};
  endfunction

  logic             v1 = 1'b0, v2 = 1'b0;
  logic [IDX_W-2:0] a1 = '0, a2 = '0;
  always @(posedge clk) begin
    v1 <= mem_en;
    a1 <= mem_addr;
    v2 <= v1;
    a2 <= a1;
  end
  assign mem_rdata = v2 ? ram_word(a2) : {7{32'hDEADBEEF}};

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < NUM_REQ; i++) gcnt[i] = 0;
    reset = 1'b1; flush = 1'b0; req = '0; req_index = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_gnt", gnt, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_null", rsp_null, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_busy", busy, 0);
    tick(); reset = 1'b0;

    // Single request, index 5 (ptr 0 -> 1)
    tick(); req = 4'b0001; req_index[0] = 8'h05; #1;
    check("single_gnt", gnt, 4'b0001);
    check("single_mem_en", mem_en, 1);
    check("single_mem_addr", mem_addr, 5);
    check("single_busy_t", busy, 0);
    tick(); req = '0; #1;
    check("single_rsp_t1", rsp_valid, 0);
    check("single_busy_t1", busy, 1);
    tick(); #1;
    check("single_rsp_t2", rsp_valid, 4'b0001);
    check("single_null_t2", rsp_null, 0);
    check("single_data_t2", rsp_data, ram_word(7'd5));
    check("single_busy_t2", busy, 1);
    tick(); #1;
    check("single_busy_t3", busy, 0);
    check("single_rsp_t3", rsp_valid, 0);

    // Null index on unit 2 (ptr 1 -> 3)
    tick(); req = 4'b0100; req_index[2] = 8'h80; #1;
    check("null_gnt", gnt, 4'b0100);
    check("null_mem_en", mem_en, 0);
    tick(); req = '0;
    tick(); #1;
    check("null_rsp", rsp_valid, 4'b0100);
    check("null_flag", rsp_null, 1);
    check("null_data", rsp_data, 0);

    // Wrap-around from ptr 3 with units 1 and 3 requesting
    tick(); req = 4'b1010; req_index[1] = 8'h21; req_index[3] = 8'h23; #1;
    check("wrap_gnt3", gnt, 4'b1000);
    check("wrap_addr3", mem_addr, 7'h23);
    tick(); req = 4'b0010; #1;
    check("wrap_gnt1", gnt, 4'b0010);
    check("wrap_addr1", mem_addr, 7'h21);
    tick(); req = 4'b0110; req_index[2] = 8'h22; #1;
    check("ptr2_gnt", gnt, 4'b0100);
    check("ptr2_rsp3", rsp_valid, 4'b1000);
    check("ptr2_data3", rsp_data, ram_word(7'h23));
    tick(); req = 4'b0010; #1;
    check("pend_block_gnt", gnt, 0);
    check("pend_block_rsp1", rsp_valid, 4'b0010);
    check("pend_block_data1", rsp_data, ram_word(7'h21));
    tick(); #1;
    check("regrant_gnt", gnt, 4'b0010);
    check("regrant_rsp2", rsp_valid, 4'b0100);
    check("regrant_data2", rsp_data, ram_word(7'h22));
    tick(); req = '0;
    tick(); #1;
    check("regrant_rsp1", rsp_valid, 4'b0010);
    tick(); #1;
    check("wrap_idle_busy", busy, 0);

    // Flush the cycle after two grants (ptr 2)
    tick(); req = 4'b0011; req_index[0] = 8'h03; req_index[1] = 8'h04; #1;
    check("flush_g0", gnt, 4'b0001);
    tick(); req = 4'b0010; #1;
    check("flush_g1", gnt, 4'b0010);
    tick(); req = 4'b0100; req_index[2] = 8'h06; flush = 1'b1; #1;
    check("flush_gnt", gnt, 0);
    check("flush_rsp", rsp_valid, 0);
    check("flush_data", rsp_data, 0);
    tick(); flush = 1'b0; #1;
    check("post_flush_busy", busy, 0);
    check("post_flush_rsp", rsp_valid, 0);
    check("post_flush_gnt", gnt, 4'b0100);
    tick(); req = '0; #1;
    check("post_flush_rsp2", rsp_valid, 0);
    tick(); #1;
    check("post_flush_new_rsp", rsp_valid, 4'b0100);
    check("post_flush_new_data", rsp_data, ram_word(7'h06));
    tick(); #1;
    check("post_flush_idle", busy, 0);

    // Async reset one cycle before the response (ptr 3)
    tick(); req = 4'b0001; req_index[0] = 8'h07; #1;
    check("arst_g0", gnt, 4'b0001);
    tick(); req = 4'b1000; req_index[3] = 8'h09; #1;
    check("arst_g3", gnt, 4'b1000);
    check("arst_busy_pre", busy, 1);
    #2 reset = 1'b1; #1;
    check("arst_gnt", gnt, 0);
    check("arst_mem_en", mem_en, 0);
    check("arst_mem_addr", mem_addr, 0);
    check("arst_busy", busy, 0);
    check("arst_rsp", rsp_valid, 0);
    tick(); req = '0; reset = 1'b0; #1;
    check("arst_no_rsp0", rsp_valid, 0);
    check("arst_no_data0", rsp_data, 0);
    tick(); #1;
    check("arst_no_rsp1", rsp_valid, 0);
    check("arst_busy_after", busy, 0);

    // Fairness: all units request continuously from ptr 0
    tick(); req = 4'b1111;
    for (int i = 0; i < NUM_REQ; i++) req_index[i] = 8'(8'h10 + i);
    for (int c = 0; c < 100; c++) begin
      #1;
      check("fair_gnt", gnt, 4'b0001 << (c % 4));
      check("fair_addr", mem_addr, 7'(7'h10 + (c % 4)));
      if (c >= 2) begin
        check("fair_rsp", rsp_valid, 4'b0001 << ((c - 2) % 4));
        check("fair_data", rsp_data, ram_word(7'(7'h10 + ((c - 2) % 4))));
      end
      for (int i = 0; i < NUM_REQ; i++) if (gnt[i]) gcnt[i]++;
      tick();
    end
    req = '0;
    repeat (3) tick();
    #1;
    check("fair_drain_busy", busy, 0);
    for (int i = 0; i < NUM_REQ; i++) check("fair_count", gcnt[i], 25);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
